// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues word reads to instruction memory, queues {pc, instr} pairs for decode,
// and handles redirects, in-flight squash and the HALT opcode stop.
module instruction_fetch_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                INSTR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                DEPTH       = 2,
    parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_en,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               halted
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;
    logic [CNT_W-1:0]   count_q, count_d;
    ptr_t               rd_q, rd_d, wr_q, wr_d;
    entry_t             fifo_q [DEPTH];
    entry_t             fifo_d [DEPTH];

    logic arrive, is_halt, pop, issue, push, do_pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign arrive  = inflight_q;
    assign is_halt = arrive && (mem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);
    assign if_valid = (count_q != '0);
    assign pop     = if_valid && if_ready;
    // Credit counts the in-flight word so an arrival always has a slot waiting for it.
    assign issue   = (state_q == RUN) && !redirect_valid && !is_halt &&
                     (int'(count_q) + int'(inflight_q) - int'(pop) < DEPTH);
    assign push    = arrive && !redirect_valid;
    assign do_pop  = pop && !redirect_valid;

    assign mem_addr = fetch_pc_q;
    assign mem_en   = issue;
    assign if_instr = if_valid ? fifo_q[rd_q].instr : '0;
    assign if_pc    = if_valid ? fifo_q[rd_q].pc : '0;
    assign halted   = (state_q == HALTED);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        count_d    = count_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        fifo_d     = fifo_q;
        if (redirect_valid) begin
            // Squash everything queued or returning; restart cleanly at the target.
            state_d    = RUN;
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_d       = '0;
            wr_d       = '0;
        end else begin
            if (issue) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
            if (push) begin
                fifo_d[wr_q] = '{pc: req_pc_q, instr: mem_instr};
                wr_d         = ptr_inc(wr_q);
                if (is_halt) state_d = HALTED;
            end
            if (do_pop) rd_d = ptr_inc(rd_q);
            case ({push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            fifo_q     <= fifo_d;
        end
    end

endmodule
